// File: rtl/snake_body_engine.sv
// Snake segment store: circular coordinate buffer plus a per-cell occupancy bitmap.
// Optional feature macro SNAKE_WRAP_EN: the head wraps across grid edges instead of dying.
module snake_body_engine #(
    parameter int GRID_W    = 52,
    parameter int GRID_H    = 36,
    parameter int MAX_LEN   = 256,
    parameter int GROW_STEP = 5,
    parameter int START_X   = 26,
    parameter int START_Y   = 18,
    localparam int CX_W  = $clog2(GRID_W),
    localparam int CY_W  = $clog2(GRID_H),
    localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [1:0]       dir,
    input  logic             dir_valid,
    input  logic             step,
    input  logic             grow,
    input  logic [CX_W-1:0]  q_x,
    input  logic [CY_W-1:0]  q_y,
    output logic             q_body,
    output logic             q_head,
    output logic [CX_W-1:0]  head_x,
    output logic [CY_W-1:0]  head_y,
    output logic [LEN_W-1:0] length,
    output logic             step_done,
    output logic             dead,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam int CELLS = GRID_W * GRID_H;
    localparam int IDX_W = $clog2(CELLS);
    localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [2:0] S_CLEAR  = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_DEAD   = 3'd4;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CELLS - 1);
    localparam logic [IDX_W-1:0] START_IDX = IDX_W'(START_Y * GRID_W + START_X);
    localparam logic [CX_W:0]    ONE_X     = {{CX_W{1'b0}}, 1'b1};
    localparam logic [CY_W:0]    ONE_Y     = {{CY_W{1'b0}}, 1'b1};
    localparam logic [CX_W:0]    LIM_X     = (CX_W + 1)'(GRID_W);
    localparam logic [CY_W:0]    LIM_Y     = (CY_W + 1)'(GRID_H);

    logic [2:0]       state;
    logic [IDX_W-1:0] clr_idx;
    logic [CELLS-1:0] bitmap;
    logic [CX_W-1:0]  buf_x [MAX_LEN];
    logic [CY_W-1:0]  buf_y [MAX_LEN];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [1:0]       dir_r;
    logic [7:0]       grow_pending;
    logic [7:0]       pend_next;
    logic [CX_W-1:0]  nh_x;
    logic [CY_W-1:0]  nh_y;
    logic             nh_off;
    logic             nh_bit;
    logic             will_grow;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [CX_W-1:0] x, input logic [CY_W-1:0] y);
        return IDX_W'(y) * IDX_W'(GRID_W) + IDX_W'(x);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_LEN - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Candidate head one cell along dir_r; one extra bit catches -1 and GRID_W/GRID_H.
    logic [CX_W:0]   sum_x;
    logic [CY_W:0]   sum_y;
    logic [CX_W-1:0] cand_x;
    logic [CY_W-1:0] cand_y;
    logic            cand_off;
    logic            cand_bit;

    always_comb begin
        sum_x = {1'b0, head_x};
        sum_y = {1'b0, head_y};
        case (dir_r)
            2'd0:    sum_y = {1'b0, head_y} - ONE_Y;
            2'd1:    sum_x = {1'b0, head_x} - ONE_X;
            2'd2:    sum_y = {1'b0, head_y} + ONE_Y;
            default: sum_x = {1'b0, head_x} + ONE_X;
        endcase
`ifdef SNAKE_WRAP_EN
        cand_off = 1'b0;
        if (sum_x == '1)        cand_x = CX_W'(GRID_W - 1);
        else if (sum_x == LIM_X) cand_x = '0;
        else                     cand_x = sum_x[CX_W-1:0];
        if (sum_y == '1)        cand_y = CY_W'(GRID_H - 1);
        else if (sum_y == LIM_Y) cand_y = '0;
        else                     cand_y = sum_y[CY_W-1:0];
`else
        cand_off = (sum_x >= LIM_X) || (sum_y >= LIM_Y);
        cand_x   = sum_x[CX_W-1:0];
        cand_y   = sum_y[CY_W-1:0];
`endif
        cand_bit = cand_off ? 1'b0 : bitmap[cell_idx(cand_x, cand_y)];
    end

    logic [CX_W-1:0] tail_x;
    logic [CY_W-1:0] tail_y;
    logic            nh_is_tail;
    logic            collision;
    logic            commit_ok;

    assign tail_x     = buf_x[tail_ptr];
    assign tail_y     = buf_y[tail_ptr];
    assign nh_is_tail = (nh_x == tail_x) && (nh_y == tail_y);
    // Stepping onto the tail is legal only when the tail is about to vacate it.
    assign collision  = nh_off || (nh_bit && !(nh_is_tail && !will_grow));
    assign commit_ok  = (state == S_COMMIT) && !collision;

    logic [9:0] pend_sum;

    always_comb begin
        pend_sum = {2'b00, grow_pending};
        if (grow && state != S_CLEAR)
            pend_sum = pend_sum + 10'(GROW_STEP);
        if (commit_ok && will_grow)
            pend_sum = pend_sum - 10'd1;
        pend_next = (pend_sum > 10'd255) ? 8'hFF : pend_sum[7:0];
    end

    // Control inputs are single-cycle qualifiers with no back-pressure: dir_valid, step,
    // grow and restart are consumed on the edge they are high, or dropped if not accepted.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state        <= S_CLEAR;
            clr_idx      <= '0;
            length       <= '0;
            dead         <= 1'b0;
            dir_r        <= 2'd3;
            grow_pending <= '0;
            head_ptr     <= '0;
            tail_ptr     <= '0;
            head_x       <= CX_W'(START_X);
            head_y       <= CY_W'(START_Y);
            nh_x         <= '0;
            nh_y         <= '0;
            nh_off       <= 1'b0;
            nh_bit       <= 1'b0;
            will_grow    <= 1'b0;
        end else begin
            grow_pending <= pend_next;
            if (dir_valid && state != S_CLEAR && dir != (dir_r ^ 2'b10))
                dir_r <= dir;
            case (state)
                S_CLEAR: begin
                    bitmap[clr_idx] <= 1'b0;
                    if (clr_idx == LAST_IDX) begin
                        bitmap[START_IDX] <= 1'b1;
                        buf_x[0]          <= CX_W'(START_X);
                        buf_y[0]          <= CY_W'(START_Y);
                        head_ptr          <= '0;
                        tail_ptr          <= '0;
                        head_x            <= CX_W'(START_X);
                        head_y            <= CY_W'(START_Y);
                        length            <= LEN_W'(1);
                        state             <= S_RUN;
                    end else begin
                        clr_idx <= clr_idx + IDX_W'(1);
                    end
                end
                S_RUN: begin
                    if (step)
                        state <= S_CHECK;
                end
                S_CHECK: begin
                    nh_x      <= cand_x;
                    nh_y      <= cand_y;
                    nh_off    <= cand_off;
                    nh_bit    <= cand_bit;
                    will_grow <= (grow_pending != 8'd0) && (length < LEN_W'(MAX_LEN));
                    state     <= S_COMMIT;
                end
                S_COMMIT: begin
                    if (collision) begin
                        dead  <= 1'b1;
                        state <= S_DEAD;
                    end else begin
                        buf_x[ptr_inc(head_ptr)]  <= nh_x;
                        buf_y[ptr_inc(head_ptr)]  <= nh_y;
                        head_ptr                  <= ptr_inc(head_ptr);
                        head_x                    <= nh_x;
                        head_y                    <= nh_y;
                        bitmap[cell_idx(nh_x, nh_y)] <= 1'b1;
                        if (will_grow) begin
                            length <= length + LEN_W'(1);
                        end else begin
                            if (!nh_is_tail)
                                bitmap[cell_idx(tail_x, tail_y)] <= 1'b0;
                            tail_ptr <= ptr_inc(tail_ptr);
                        end
                        state <= S_RUN;
                    end
                end
                S_DEAD: begin
                    state <= S_DEAD;
                end
                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

    logic             q_in;
    logic             q_hit_head;
    logic [IDX_W-1:0] q_idx;

    assign q_in       = ({1'b0, q_x} < LIM_X) && ({1'b0, q_y} < LIM_Y);
    assign q_hit_head = (q_x == head_x) && (q_y == head_y);
    assign q_idx      = q_in ? cell_idx(q_x, q_y) : '0;

    always_ff @(posedge clk) begin
        if (reset || restart || state == S_CLEAR || !q_in) begin
            q_body <= 1'b0;
            q_head <= 1'b0;
        end else begin
            q_head <= q_hit_head;
            q_body <= bitmap[q_idx] && !q_hit_head;
        end
    end

    assign step_done = commit_ok;
    assign busy      = (state == S_CLEAR) || (state == S_CHECK) || (state == S_COMMIT);
    assign dbg_state = state;

endmodule
